race_out_buf: RTL and testbench
===============================

Name: race_out_buf

Overview:
- Output buffer stage directly downstream of the RACE filter top level.
- Captures each filtered complex sample (real/imag) when the filter's output register updates with a valid sample.
- Stores samples in a first-word-fall-through FIFO and presents them on a valid/ready stream with a frame marker every FRAME_LEN samples.
- Decouples the strobe-paced filter from a back-pressuring consumer and reports overflow.

Parameters:
- SAMPLE_SIZE, 16, width of each real/imag component (matches filter output).
- DEPTH, 16, FIFO depth in samples; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).
- FRAME_LEN, 64, samples per output frame; 1..65535.
- FCNT_W, 16, frame counter width.
- DROP_W, 16, drop counter width.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush: empties the FIFO and clears the frame counter, ovf and drop_cnt.
- in_load  in  1  one-cycle pulse, coincident with the filter's output register update (data_ready of the upstream stage).
- in_valid  in  1  valid flag of the upstream sample (valid_out of the filter).
- in_real  in  SAMPLE_SIZE  filtered real sample.
- in_imag  in  SAMPLE_SIZE  filtered imaginary sample.
- m_valid  out  1  head sample available.
- m_ready  in  1  consumer accepts the head sample.
- m_data  out  2*SAMPLE_SIZE  {real, imag}; real in the MSBs.
- m_last  out  1  head sample is the last of a frame.
- level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- ovf  out  1  sticky: at least one sample dropped.
- drop_cnt  out  DROP_W  saturating count of dropped samples.

Behaviour:
- Reset (rst=1, asynchronous):
  - Pointers = 0, level = 0, m_valid = 0, m_last = 0, m_data = 0, ovf = 0, drop_cnt = 0, frame counter = 0.
  - Storage contents need not be reset.
- Push condition: push_req = in_load & in_valid. in_load with in_valid=0 is ignored with no side effects.
- Pop condition: pop = m_valid & m_ready.
- Push accept:
  - Accepted when level < DEPTH, or when level == DEPTH and pop occurs in the same cycle (pop frees the slot; the write goes to the freed location).
  - Otherwise the sample is dropped: ovf is set, and drop_cnt increments, saturating at all-ones.
- Latency: an accepted push into an empty FIFO gives m_valid=1 and m_data = that sample on the next cycle (1-cycle latency). m_data always reflects the head entry (FWFT).
- Level update: level += accepted push, -= pop, both evaluated in the same cycle. Simultaneous push and pop at level 0 is impossible (m_valid=0). Simultaneous push and pop at any other level leaves level unchanged.
- Pointers: ADDR_W bits, wrap naturally at DEPTH. Full/empty are derived from level, not from pointer equality.
- Frame counter:
  - Counts popped samples, 0..FRAME_LEN-1.
  - m_last = m_valid & (fcnt == FRAME_LEN-1).
  - On pop, fcnt wraps to 0 after FRAME_LEN-1, otherwise increments.
  - FRAME_LEN=1 means m_last=m_valid.
- Stream rules:
  - m_data and m_last are held stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a pop.
- clr:
  - Takes priority over push and pop in the same cycle. Pending samples are discarded and the push in that cycle is dropped without counting.
  - Next cycle: level=0, m_valid=0, fcnt=0, ovf=0, drop_cnt=0.
- Reset mid-operation: all state returns to reset values immediately. The first push after rst deasserts behaves as into an empty FIFO.
- Arithmetic: no sample modification; samples are passed through bit-exact.

Decomposition:
- Shared package: the SAMPLE_SIZE default, the packed-sample width (2*SAMPLE_SIZE), and a localparam for real/imag bit slicing, shared with the filter top.
- One sub-module: race_fifo_mem, a simple dual-port register array (write port: addr/data/we; asynchronous read port).
- Control, counters and stream logic stay in race_out_buf.

Test Plan:
- Single sample: rst, then in_load=1 with in_valid=1, in_real=16'h1234, in_imag=16'hFEDC, m_ready=0 -> next cycle m_valid=1, m_data=32'h1234FEDC, level=1. Holds stable 10 cycles; m_ready=1 one cycle -> level=0, m_valid=0.
- Invalid ignored: in_load pulses with in_valid=0 -> level stays 0, ovf=0, drop_cnt=0.
- Overflow: m_ready=0, 20 valid pushes with DEPTH=16 -> level=16, ovf=1, drop_cnt=4. First 16 samples drain in order; samples 17-20 are absent.
- Full plus simultaneous pop: level=16, push and pop in the same cycle -> level stays 16, ovf unchanged, new sample appears last in the drain order.
- Framing: FRAME_LEN=4, 9 samples pushed, m_ready=1 -> m_last=1 on the 4th and 8th popped samples only. With m_ready toggling 1/0, m_last still marks samples 4 and 8.
- clr and reset: clr asserted with level=5, ovf=1, plus a push in the same cycle -> next cycle level=0, ovf=0, drop_cnt=0, m_valid=0. Async rst asserted mid-drain -> outputs go to reset values without a clock edge.

Source files
------------

// File: rtl/race_out_buf_pkg.sv
// rtl/race_out_buf_pkg.sv - shared sample widths for the RACE filter output path
package race_out_buf_pkg;

    localparam int RACE_SAMPLE_SIZE = 16;
    localparam int RACE_SAMPLE_W    = 2 * RACE_SAMPLE_SIZE;
    // Real component occupies the upper half of a packed sample.
    localparam int RACE_REAL_LSB    = RACE_SAMPLE_SIZE;

endpackage

// File: rtl/race_fifo_mem.sv
// rtl/race_fifo_mem.sv - simple dual-port register array, sync write / async read
module race_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/race_out_buf.sv
// rtl/race_out_buf.sv - FWFT output buffer with framing and overflow accounting
module race_out_buf
    import race_out_buf_pkg::*;
#(
    parameter int SAMPLE_SIZE = RACE_SAMPLE_SIZE,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int FRAME_LEN   = 64,
    parameter int FCNT_W      = 16,
    parameter int DROP_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_load,
    input  logic                     in_valid,
    input  logic [SAMPLE_SIZE-1:0]   in_real,
    input  logic [SAMPLE_SIZE-1:0]   in_imag,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [2*SAMPLE_SIZE-1:0] m_data,
    output logic                     m_last,
    output logic [ADDR_W:0]          level,
    output logic                     ovf,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int                SW        = 2 * SAMPLE_SIZE;
    localparam logic [ADDR_W:0]   LEVEL_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic          push_req;
    logic          pop;
    logic          accept;
    logic          we;
    logic [SW-1:0] rd_data;

    assign m_valid  = (level_q != '0);
    assign pop      = m_valid & m_ready;
    assign push_req = in_load & in_valid;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign accept   = push_req & ((level_q != LEVEL_MAX) | pop);
    assign we       = accept & ~clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        fcnt_d   = fcnt_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            fcnt_d   = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                fcnt_d   = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (push_req && !accept) begin
                ovf_d = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            fcnt_q   <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            fcnt_q   <= fcnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    race_fifo_mem #(
        .DATA_W (SW),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (we),
        .wr_addr (wr_ptr_q),
        .wr_data ({in_real, in_imag}),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    // Storage is not reset, so the head is masked until a sample is present.
    assign m_data   = m_valid ? rd_data : '0;
    assign m_last   = m_valid & (fcnt_q == FCNT_LAST);
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_race_out_buf.sv
// tb/tb_race_out_buf.sv - directed-vector bench for race_out_buf
module tb_race_out_buf;
    import race_out_buf_pkg::*;

    localparam int SS     = RACE_SAMPLE_SIZE;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int FLEN   = 4;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              rst, clr, in_load, in_valid, m_ready;
    logic [SS-1:0]     in_real, in_imag;
    logic              m_valid, m_last, ovf;
    logic [2*SS-1:0]   m_data;
    logic [ADDR_W:0]   level;
    logic [DROP_W-1:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    race_out_buf #(
        .SAMPLE_SIZE (SS),
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .FRAME_LEN   (FLEN),
        .FCNT_W      (16),
        .DROP_W      (DROP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_load  (in_load),
        .in_valid (in_valid),
        .in_real  (in_real),
        .in_imag  (in_imag),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .level    (level),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*SS-1:0] smp(input int i);
        logic [SS-1:0] r;
        r = SS'(i);
        return {r, ~r};
    endfunction

    task automatic push_n(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            in_load  = 1'b1;
            in_valid = 1'b1;
            {in_real, in_imag} = smp(base + i);
            step();
        end
        in_load = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        int k;
        int cyc;
        rst = 1'b1; clr = 1'b0; in_load = 1'b0; in_valid = 1'b0;
        m_ready = 1'b0; in_real = '0; in_imag = '0;
        #12;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        step();

        // Single sample, held under back-pressure then popped
        in_load = 1'b1; in_valid = 1'b1; in_real = 16'h1234; in_imag = 16'hFEDC;
        step();
        in_load = 1'b0;
        chk("one_valid", 64'(m_valid), 64'd1);
        chk("one_data", 64'(m_data), 64'h1234FEDC);
        chk("one_level", 64'(level), 64'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("one_hold", 64'(m_data), 64'h1234FEDC);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("one_pop_level", 64'(level), 64'd0);
        chk("one_pop_valid", 64'(m_valid), 64'd0);

        // in_load without in_valid is ignored
        in_load = 1'b1; in_valid = 1'b0;
        step(); step(); step();
        in_load = 1'b0;
        chk("inv_level", 64'(level), 64'd0);
        chk("inv_ovf", 64'(ovf), 64'd0);
        chk("inv_drop", 64'(drop_cnt), 64'd0);
        do_clr();

        // Overflow: 20 pushes into 16 slots
        push_n(0, 20);
        chk("ovf_level", 64'(level), 64'd16);
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_drop", 64'(drop_cnt), 64'd4);

        // Full with simultaneous push and pop
        in_load = 1'b1; in_valid = 1'b1; {in_real, in_imag} = smp(100);
        m_ready = 1'b1;
        chk("full_head", 64'(m_data), 64'(smp(0)));
        step();
        in_load = 1'b0;
        chk("full_pp_level", 64'(level), 64'd16);
        chk("full_pp_drop", 64'(drop_cnt), 64'd4);
        chk("full_pp_ovf", 64'(ovf), 64'd1);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_data", 64'(m_data), 64'(smp(i == 16 ? 100 : i)));
            step();
        end
        m_ready = 1'b0;
        chk("drain_empty", 64'(m_valid), 64'd0);
        do_clr();
        chk("clr_ovf", 64'(ovf), 64'd0);
        chk("clr_drop", 64'(drop_cnt), 64'd0);

        // Framing with m_ready held high
        push_n(200, 9);
        m_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            chk("frm_valid", 64'(m_valid), 64'd1);
            chk("frm_last", 64'(m_last), 64'((i == 4) || (i == 8)));
            step();
        end
        m_ready = 1'b0;
        do_clr();

        // Framing with m_ready toggling
        push_n(300, 9);
        k = 1;
        cyc = 0;
        while (k <= 9 && cyc < 40) begin
            m_ready = (cyc % 2 == 0);
            chk("tog_last", 64'(m_last), 64'((k == 4) || (k == 8)));
            chk("tog_data", 64'(m_data), 64'(smp(300 + k - 1)));
            step();
            if (m_ready) k++;
            cyc++;
        end
        m_ready = 1'b0;
        chk("tog_done", 64'(k), 64'd10);

        // clr with level 5, ovf set, and a coincident push
        do_clr();
        push_n(400, 17);
        m_ready = 1'b1;
        for (int i = 0; i < 11; i++) step();
        m_ready = 1'b0;
        chk("pre_clr_level", 64'(level), 64'd5);
        chk("pre_clr_ovf", 64'(ovf), 64'd1);
        clr = 1'b1; in_load = 1'b1; in_valid = 1'b1; {in_real, in_imag} = smp(500);
        step();
        clr = 1'b0; in_load = 1'b0;
        chk("clr_level", 64'(level), 64'd0);
        chk("clr_valid", 64'(m_valid), 64'd0);
        chk("clr_ovf2", 64'(ovf), 64'd0);
        chk("clr_drop2", 64'(drop_cnt), 64'd0);

        // Async reset mid-drain
        push_n(600, 3);
        m_ready = 1'b1;
        step();
        chk("mid_level", 64'(level), 64'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(m_valid), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_data", 64'(m_data), 64'd0);
        chk("arst_last", 64'(m_last), 64'd0);
        m_ready = 1'b0;
        step();
        rst = 1'b0;
        push_n(700, 1);
        chk("post_rst_level", 64'(level), 64'd1);
        chk("post_rst_data", 64'(m_data), 64'(smp(700)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
